uart_tx_responder: RTL and testbench

Memory-mapped UART transmitter that acts as a responder on the CPU data-memory bus: addr, write enable, write data and read data.
- Decodes a 2-word window at BASE_ADDR. Stores push bytes into a TX FIFO; loads return status.
- Drains the FIFO as 8N1 serial frames on the tx pin.
- Sits beside the RAM in the top level; the top selects this block's read data when sel is high.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_responder_sync_fifo.sv | 62 ++++++
 rtl/uart_tx_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_tx_responder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
// The PARITY state is always declared; it is only reachable when UART_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic [2:0] TXDATA_OFF = 3'h0;
    localparam logic [2:0] STATUS_OFF = 3'h4;

    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_CNT_LSB   = 4;
    localparam int ST_CNT_MSB   = 7;

    localparam int BAUD_W = 16;

    // STATUS only has a 4-bit count field; deeper FIFOs report 15 when fuller than that.
    function automatic logic [3:0] sat_count4(input logic [31:0] cnt);
        return (cnt > 32'd15) ? 4'hF : cnt[3:0];
    endfunction

endpackage

// File: rtl/uart_tx_responder_sync_fifo.sv
// Synchronous FIFO holding bytes waiting for transmission.
// The head entry is presented combinationally on rdata; push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the count before the edge, so a push is refused even when a pop happens alongside it.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_responder.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus: TXDATA at BASE_ADDR+0, STATUS at BASE_ADDR+4.
// Define UART_PARITY_EN to append an even-parity bit before the stop bit (11-bit frames).
module uart_tx_responder
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_F000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_enable,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        sel,
    output logic        tx,
    output logic        irq_empty
);

    localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    // Bus decode
    logic [2:0]    offset;
    logic          bus_wr;
    logic          wr_txdata;
    logic          wr_status;
    logic          ovf_q;
    logic [31:0]   status_word;
    logic          unused_bits;

    // FIFO interface
    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // Transmitter
    tx_state_e         state_q;
    tx_state_e         state_d;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]        bit_q;
    logic [2:0]        bit_d;
    logic [7:0]        shift_q;
    logic [7:0]        shift_d;
    logic              tx_q;
    logic              tx_d;
    logic              bit_done;
    logic              busy;
`ifdef UART_PARITY_EN
    logic              parity_q;
    logic              parity_d;
`endif

    assign sel         = (addr[31:3] == BASE_ADDR[31:3]);
    assign offset      = {addr[2], 2'b00};
    assign bus_wr      = clk_enable & we & sel;
    assign wr_txdata   = bus_wr & (offset == TXDATA_OFF);
    assign wr_status   = bus_wr & (offset == STATUS_OFF);
    assign fifo_push   = wr_txdata;
    assign unused_bits = ^{addr[1:0], data_in[31:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (data_in[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign busy     = (state_q != IDLE);
    assign bit_done = (baud_q == BAUD_LAST);
    assign tx       = tx_q;

    always_comb begin
        status_word                         = '0;
        status_word[ST_CNT_MSB:ST_CNT_LSB]  = sat_count4(32'(fifo_count));
        status_word[ST_OVF_BIT]             = ovf_q;
        status_word[ST_BUSY_BIT]            = busy;
        status_word[ST_EMPTY_BIT]           = fifo_empty;
        status_word[ST_FULL_BIT]            = fifo_full;
    end

    // Bus-side registers: sticky overflow, read data, empty interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q     <= 1'b0;
            data_out  <= '0;
            irq_empty <= 1'b1;
        end else begin
            if (wr_txdata && fifo_full) begin
                ovf_q <= 1'b1;
            end else if (wr_status && data_in[ST_OVF_BIT]) begin
                ovf_q <= 1'b0;
            end
            if (clk_enable) begin
                data_out <= (sel && (offset == STATUS_OFF)) ? status_word : '0;
            end
            irq_empty <= fifo_empty && (state_q == IDLE);
        end
    end

    // Transmit FSM state register; tx is registered so the pin never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q  <= shift_d;
`ifdef UART_PARITY_EN
        parity_q <= parity_d;
`endif
    end

    // tx_d is the level of the state being entered, so the pin lines up with the state register
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
`ifdef UART_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    baud_d   = '0;
                    state_d  = START;
                    tx_d     = 1'b0;
`ifdef UART_PARITY_EN
                    parity_d = ^fifo_rdata;
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_responder.sv
// Bench for uart_tx_responder: decode vector table, directed frame/overflow/reset sequences and random bus
// traffic, all checked every clock against a byte-queue model of the FIFO and the serial frame format.
module tb_uart_tx_responder;

    localparam logic [31:0] BASE  = 32'h0000_F000;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
`ifdef UART_PARITY_EN
    localparam int          FBITS = 11;
`else
    localparam int          FBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_enable = 1'b1;
    logic [31:0] addr = BASE + 32'd4;
    logic        we = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic        sel;
    logic        tx;
    logic        irq_empty;

    always #5 clk = ~clk;

    uart_tx_responder #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_enable (clk_enable),
        .addr       (addr),
        .we         (we),
        .data_in    (data_in),
        .data_out   (data_out),
        .sel        (sel),
        .tx         (tx),
        .irq_empty  (irq_empty)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: bytes waiting, sticky overflow, and the frame currently on the wire
    logic [7:0]  q[$];
    logic        m_ovf = 1'b0;
    logic        m_act = 1'b0;
    int          fcyc = 0;
    logic [7:0]  cur = 8'd0;
    logic [31:0] m_dout = 32'd0;
    logic        m_irq = 1'b1;

    typedef struct {
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_sel;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
`ifdef UART_PARITY_EN
        if (pos == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] status_of(input int cnt, input logic ovf, input logic busy);
        logic [3:0] c4;
        c4 = (cnt > 15) ? 4'd15 : 4'(cnt);
        return {24'd0, c4, ovf, busy, (cnt == 0), (cnt == DEPTH)};
    endfunction

    // Runs just after each rising edge: advance the model through that edge and compare all outputs.
    task automatic model_step();
        int   pre_cnt;
        logic pre_act;
        logic sel_exp;
        logic exp_tx;
        sel_exp = (addr[31:3] == BASE[31:3]);
        if (rst) begin
            q.delete();
            m_ovf  = 1'b0;
            m_act  = 1'b0;
            fcyc   = 0;
            m_dout = 32'd0;
            m_irq  = 1'b1;
            exp_tx = 1'b1;
        end else begin
            pre_cnt = q.size();
            pre_act = m_act;
            if (clk_enable)
                m_dout = (sel_exp && addr[2]) ? status_of(pre_cnt, m_ovf, pre_act) : 32'd0;
            m_irq = (pre_cnt == 0) && !pre_act;
            if (pre_act) begin
                fcyc++;
                if (fcyc == FBITS * CPB) m_act = 1'b0;
            end else if (pre_cnt > 0) begin
                cur   = q.pop_front();
                m_act = 1'b1;
                fcyc  = 0;
            end
            exp_tx = m_act ? frame_bit(cur, fcyc / CPB) : 1'b1;
            if (clk_enable && we && sel_exp) begin
                if (!addr[2]) begin
                    if (pre_cnt >= DEPTH) m_ovf = 1'b1;
                    else q.push_back(data_in[7:0]);
                end else if (data_in[3]) begin
                    m_ovf = 1'b0;
                end
            end
        end
        check("model_tx", 32'(tx), 32'(exp_tx));
        check("model_data_out", data_out, m_dout);
        check("model_irq_empty", 32'(irq_empty), 32'(m_irq));
        check("model_sel", 32'(sel), 32'(sel_exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        clk_enable = 1'b1;
        we         = 1'b0;
        addr       = BASE + 32'd4;
        data_in    = 32'd0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        clk_enable = 1'b1;
        we         = 1'b1;
        addr       = a;
        data_in    = d;
        tick();
        bus_idle();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (irq_empty !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(irq_empty), 32'd1);
    endtask

    // Assumes FIFO empty and transmitter idle on entry.
    task automatic send_frame(input logic [7:0] b);
        logic [10:0] ef;
        int bad;
        int busy_bad;
        bad = 0;
        busy_bad = 0;
`ifdef UART_PARITY_EN
        ef = {1'b1, ^b, b, 1'b0};
`else
        ef = {2'b01, b, 1'b0};
`endif
        bus_write(BASE, {24'd0, b});
        for (int i = 0; i < FBITS * CPB; i++) begin
            tick();
            if (tx !== ef[i / CPB]) bad++;
            if (i > 0 && data_out[2] !== 1'b1) busy_bad++;
        end
        check("frame_bits", 32'(bad), 32'd0);
        check("frame_busy", 32'(busy_bad), 32'd0);
        tick();
        check("frame_idle_tx", 32'(tx), 32'd1);
        check("frame_irq_lag", 32'(irq_empty), 32'd0);
        tick();
        check("frame_irq_set", 32'(irq_empty), 32'd1);
    endtask

    initial begin
        int bad;
        int wr_pct;

        tbl[0]  = '{1'b1, 1'b0, 32'h0000_F004, 32'h0,  1'b1, 32'h2};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_F000, 32'h0,  1'b1, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0000_F008, 32'h0,  1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0000_F007, 32'h0,  1'b1, 32'h2};
        tbl[4]  = '{1'b1, 1'b0, 32'h0000_E004, 32'h0,  1'b0, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 32'h0000_F004, 32'h0,  1'b1, 32'h2};
        tbl[6]  = '{1'b0, 1'b0, 32'h0000_F000, 32'h0,  1'b1, 32'h2};
        tbl[7]  = '{1'b1, 1'b1, 32'h0000_F004, 32'h8,  1'b1, 32'h2};
        tbl[8]  = '{1'b0, 1'b1, 32'h0000_F000, 32'h55, 1'b1, 32'h2};
        tbl[9]  = '{1'b1, 1'b1, 32'h0001_F000, 32'h66, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 32'h0000_F004, 32'h0,  1'b1, 32'h2};
        tbl[11] = '{1'b1, 1'b0, 32'hFFFF_F004, 32'h0,  1'b0, 32'h0};

        // Reset held for three clocks
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_irq", 32'(irq_empty), 32'd1);
        check("reset_dout", data_out, 32'd0);
        rst = 1'b0;
        tick();
        check("reset_status", data_out, 32'h0000_0002);

        for (int i = 0; i < 12; i++) begin
            clk_enable = tbl[i].en;
            we         = tbl[i].we;
            addr       = tbl[i].addr;
            data_in    = tbl[i].wdata;
            #1;
            check("tbl_sel", 32'(sel), 32'(tbl[i].exp_sel));
            tick();
            check("tbl_dout", data_out, tbl[i].exp_dout);
        end
        bus_idle();
        tick();

        // Single frames, waveform compared bit by bit
        send_frame(8'hA5);
        send_frame(8'h07);

        // Three back-to-back bytes
        bus_write(BASE, 32'h01);
        bus_write(BASE, 32'h02);
        bus_write(BASE, 32'h03);
        tick();
        check("b2b_status", data_out, 32'h0000_0024);
        wait_idle(3 * (FBITS * CPB + 1) + 20);

        // Overflow: ten quick pushes, one pops, eight held, one dropped
        for (int i = 0; i < 10; i++) bus_write(BASE, 32'h10 + 32'(i));
        tick();
        check("ovf_status", data_out, 32'h0000_008D);
        bus_write(BASE + 32'd4, 32'h8);
        tick();
        check("ovf_cleared", data_out, 32'h0000_0085);
        wait_idle(DEPTH * (FBITS * CPB + 1) + 60);

        // Reset during data bit 3 with a second byte still queued
        bus_write(BASE, 32'h52);
        bus_write(BASE, 32'h3C);
        for (int i = 0; i < 4 * CPB + 1; i++) tick();
        check("pre_rst_tx", 32'(tx), 32'd0);
        rst = 1'b1;
        tick();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_irq", 32'(irq_empty), 32'd1);
        check("rst_dout", data_out, 32'd0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (tx !== 1'b1) bad++;
        end
        check("no_frame_after_rst", 32'(bad), 32'd0);
        check("status_after_rst", data_out, 32'h0000_0002);

        // Random bus traffic in three write-density phases
        for (int c = 0; c < 1500; c++) begin
            wr_pct = (c < 500) ? 5 : ((c < 1000) ? 40 : 10);
            clk_enable = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 99) < wr_pct);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: addr = BASE | 32'($urandom_range(0, 3));
                5, 6, 7:       addr = (BASE + 32'd4) | 32'($urandom_range(0, 3));
                8:             addr = BASE + 32'd8;
                default:       addr = $urandom;
            endcase
            data_in = $urandom;
            tick();
        end
        bus_idle();
        wait_idle(DEPTH * (FBITS * CPB + 1) + 60);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
